// File: rtl/calc_input_pkg.sv
// Shared types and constants for the calculator push-button conditioner.
package calc_input_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } btn_state_e;

  // Defaults assume a 50 MHz clk_g.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_HOLD_CYCLES     = 25000000;
  localparam int DEF_REPEAT_CYCLES   = 5000000;

  // Bits needed for a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_core.sv
// Two-flop synchroniser and debounce counter; yields the clean level, registered
// edge strobes and the next-edge rise/fall events used by the hold FSM.
module btn_debounce_core
  import calc_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          press_q, release_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  always_comb begin
    flip    = (s2_q != level_q) && (cnt_q == TERM);
    cnt_d   = '0;
    if ((s2_q != level_q) && !flip) cnt_d = cnt_q + 1'b1;
    level_d = flip ? s2_q : level_q;
  end

  assign rise_o = flip & s2_q;
  assign fall_o = flip & ~s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= button_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= rise_o;
      release_q <= fall_o;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/calc_button_cond.sv
// Push-button conditioner for calculator_hex: debounced level, press/release
// strobes and long-press auto-repeat.
module calc_button_cond
  import calc_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat,
  output logic btn_long
);

  localparam int            MAXC      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int            HW        = cnt_w(MAXC);
  localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_TERM  = HW'(REPEAT_CYCLES - 1);

  logic rise, fall;

  btn_debounce_core #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_core (
    .clk       (clk),
    .rst       (rst),
    .button_i  (button),
    .level_o   (btn_level),
    .press_o   (btn_press),
    .release_o (btn_release),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;
  logic          long_q, long_d;

  // FSM runs off the same-edge debounce events so repeat/long line up with the strobes.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == HOLD_TERM) begin
          hold_d = '0;
          if (REPEAT_EN) begin
            state_d = REPEATING;
            rep_d   = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      REPEATING: begin
        if (fall) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == REP_TERM) begin
          rep_d  = 1'b1;
          hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
    long_d = (state_d == REPEATING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rep_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      long_q  <= long_d;
    end
  end

  assign btn_repeat = rep_q;
  assign btn_long   = long_q;

endmodule

// File: tb/tb_calc_button_cond.sv
// Bench for calc_button_cond: window-based reference model checked every cycle,
// a pulse-length vector table, directed timing sequences and random stimulus.
module tb_calc_button_cond;
  localparam int D = 4, H = 10, R = 3;

  logic clk = 1'b0, rst = 1'b1, button = 1'b0;
  logic l1, p1, r1, q1, g1;
  logic l0, p0, r0, q0, g0;

  always #5 clk = ~clk;

  calc_button_cond #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) u_en (
    .clk(clk), .rst(rst), .button(button),
    .btn_level(l1), .btn_press(p1), .btn_release(r1), .btn_repeat(q1), .btn_long(g1));

  calc_button_cond #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) u_dis (
    .clk(clk), .rst(rst), .button(button),
    .btn_level(l0), .btn_press(p0), .btn_release(r0), .btn_repeat(q0), .btn_long(g0));

  int checks = 0, failures = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the level flips once the last D synchronised samples all disagree with it.
  bit s1m, s2m, lvm, ep, er, eq, eg;
  bit win[$];
  int pe = -1;

  task model_step(input bit b, input bit r);
    bit pre, flip;
    int d;
    if (r) begin
      s1m = 0; s2m = 0; lvm = 0; win.delete(); pe = -1;
      ep = 0; er = 0; eq = 0; eg = 0;
      return;
    end
    pre = s2m; s2m = s1m; s1m = b;
    win.push_back(pre);
    if (win.size() > D) void'(win.pop_front());
    flip = (win.size() == D);
    foreach (win[i]) if (win[i] == lvm) flip = 0;
    ep = flip && !lvm;
    er = flip && lvm;
    eq = 0;
    if (er) pe = -1;
    if (ep) pe = cyc;
    if (!er && !ep && lvm && pe >= 0) begin
      d  = cyc - pe;
      eq = (d == H) || (d > H && ((d - H) % R) == 0);
    end
    if (flip) lvm = !lvm;
    eg = lvm && pe >= 0 && (cyc - pe) >= H;
  endtask

  int n_p1 = 0, n_r1 = 0, n_q1 = 0, n_p0 = 0, n_r0 = 0, n_q0 = 0, n_g0 = 0;
  int last_p = 0, last_r = 0;
  bit rel_long = 0, rel_rep = 0, press_rep = 0;
  int rep_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step(button, rst);
    #1;
    check("level_en",   l1, lvm);
    check("press_en",   p1, ep);
    check("release_en", r1, er);
    check("repeat_en",  q1, eq);
    check("long_en",    g1, eg);
    check("level_dis",  l0, lvm);
    check("press_dis",  p0, ep);
    check("release_dis", r0, er);
    check("repeat_dis", q0, 0);
    check("long_dis",   g0, 0);
    if (p1) begin n_p1++; last_p = cyc; if (q1) press_rep = 1; end
    if (r1) begin n_r1++; last_r = cyc; if (g1) rel_long = 1; if (q1) rel_rep = 1; end
    if (q1) begin n_q1++; rep_q.push_back(cyc); end
    if (p0) n_p0++;
    if (r0) n_r0++;
    if (q0) n_q0++;
    if (g0) n_g0++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int len;
    int presses;
    int releases;
    int repeats;
  } vec_t;
  vec_t vt[8];

  initial begin
    int t0, t1, ts, tr, bp, br, bq, bp0, br0;
    bit bounce[5];

    vt[0] = '{1, 0, 0, 0};
    vt[1] = '{3, 0, 0, 0};
    vt[2] = '{4, 1, 1, 0};
    vt[3] = '{10, 1, 1, 0};
    vt[4] = '{11, 1, 1, 1};
    vt[5] = '{13, 1, 1, 1};
    vt[6] = '{14, 1, 1, 2};
    vt[7] = '{40, 1, 1, 10};
    bounce = '{1, 0, 1, 1, 0};

    // Reset state
    rst = 1; button = 0;
    tick(3);
    check("reset_outputs", {l1, p1, r1, q1, g1, l0, p0, r0, q0, g0}, 0);
    rst = 0;
    tick(5);

    // Clean press held long, then release
    bp = n_p1; br = n_r1; bp0 = n_p0; br0 = n_r0;
    rep_q.delete();
    t0 = cyc + 1;
    button = 1;
    tick(40);
    button = 0;
    t1 = cyc + 1;
    tick(15);
    check("clean_press_count", n_p1 - bp, 1);
    check("clean_press_time", last_p, t0 + 5);
    check("repeat_count", rep_q.size(), 10);
    if (rep_q.size() >= 10) begin
      check("repeat_first", rep_q[0], t0 + 15);
      check("repeat_second", rep_q[1], t0 + 18);
      check("repeat_last", rep_q[9], t0 + 42);
    end
    check("release_count", n_r1 - br, 1);
    check("release_time", last_r, t1 + 5);
    check("long_at_release", rel_long, 0);
    check("repeat_at_release", rel_rep, 0);
    check("press_and_repeat", press_rep, 0);
    check("dis_press_count", n_p0 - bp0, 1);
    check("dis_release_count", n_r0 - br0, 1);
    check("dis_repeat_total", n_q0, 0);
    check("dis_long_total", n_g0, 0);

    // Bounce then steady high
    bp = n_p1;
    for (int i = 0; i < 5; i++) begin
      button = bounce[i];
      tick(1);
    end
    ts = cyc + 1;
    button = 1;
    tick(20);
    check("bounce_press_count", n_p1 - bp, 1);
    check("bounce_press_time", last_p, ts + 5);
    button = 0;
    tick(20);

    // Reset while repeating with button held
    button = 1;
    tick(25);
    check("long_before_reset", g1, 1);
    br = n_r1;
    rst = 1;
    tick(1);
    check("outputs_in_reset", {l1, p1, r1, q1, g1}, 0);
    tick(1);
    rst = 0;
    tr = cyc + 1;
    tick(15);
    check("no_release_on_reset", n_r1 - br, 0);
    check("press_after_reset", last_p, tr + 5);
    button = 0;
    tick(20);

    // Pulse-length table
    for (int i = 0; i < 8; i++) begin
      bp = n_p1; br = n_r1; bq = n_q1; bp0 = n_q0;
      button = 1;
      tick(vt[i].len);
      button = 0;
      tick(20);
      check($sformatf("vec%0d_presses", i), n_p1 - bp, vt[i].presses);
      check($sformatf("vec%0d_releases", i), n_r1 - br, vt[i].releases);
      check($sformatf("vec%0d_repeats", i), n_q1 - bq, vt[i].repeats);
      check($sformatf("vec%0d_dis_repeats", i), n_q0 - bp0, 0);
      check($sformatf("vec%0d_level_low", i), l1, 0);
    end

    // Random runs with occasional resets
    repeat (400) begin
      button = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 30) == 0);
      tick($urandom_range(1, 2));
      rst = 0;
      tick($urandom_range(0, 20));
    end
    button = 0;
    tick(30);
    check("final_level", l1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
